pipelined_cla_addsub: RTL and testbench

- Parametrised, pipelined successor to the team's two-block 8-bit carry-lookahead adder/subtractor.
- WIDTH-bit operands are split into BLOCK-bit carry-lookahead slices. One register stage sits between slices, so the inter-block carry is registered rather than rippled combinationally.
- Valid/ready handshake on both sides, sustained throughput of one operation per clock.
- Used as the shared add/sub datapath for wider ALU and accumulator blocks.

---
 rtl/pipelined_cla_addsub.sv | 174 +++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined WIDTH-bit carry-lookahead adder/subtractor
// Optional ovf/zero outputs are built when CLA_FLAGS_EN is defined.
module pipelined_cla_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             mode,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CLA_FLAGS_EN
    ,
    output logic             ovf,
    output logic             zero
`endif
);
    localparam int NB = WIDTH / BLOCK;

    logic en;

    // The whole pipe advances or holds as one; bubbles are never squeezed out.
    assign en       = ~out_valid | out_ready;
    assign in_ready = en & ~reset;

    for (genvar k = 0; k < NB; k++) begin : g_st
        localparam int LO = k * BLOCK;
        localparam int HI = LO + BLOCK;

        logic [WIDTH-1:LO] x_src;
        logic [WIDTH-1:LO] y_src;
        logic              mode_src;
        logic              c_src;
        logic              vld_src;
        logic [BLOCK-1:0]  yb;
        logic [BLOCK-1:0]  s;
        logic              co;
        logic [HI-1:0]     res_d;
        logic [HI-1:0]     res_q;
        logic              c_q;
        logic              vld_q;

        if (k == 0) begin : g_in
            assign x_src    = x;
            assign y_src    = y;
            assign mode_src = mode;
            assign c_src    = cin;
            assign vld_src  = in_valid;
            assign res_d    = s;
        end else begin : g_in
            assign x_src    = g_st[k-1].g_fwd.x_q;
            assign y_src    = g_st[k-1].g_fwd.y_q;
            assign mode_src = g_st[k-1].g_fwd.mode_q;
            assign c_src    = g_st[k-1].c_q;
            assign vld_src  = g_st[k-1].vld_q;
            assign res_d    = {s, g_st[k-1].res_q};
        end

        assign yb = y_src[HI-1:LO] ^ {BLOCK{mode_src}};

        cla_slice #(.BLOCK(BLOCK)) u_slice (
            .a_i (x_src[HI-1:LO]),
            .b_i (yb),
            .c_i (c_src),
            .s_o (s),
            .c_o (co)
        );

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                res_q <= '0;
            end else if (en) begin
                vld_q <= vld_src;
                c_q   <= co;
                res_q <= res_d;
            end
        end

        // Operand bits still waiting for their slice travel down with the op.
        if (k < NB - 1) begin : g_fwd
            logic [WIDTH-1:HI] x_q;
            logic [WIDTH-1:HI] y_q;
            logic              mode_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    x_q    <= '0;
                    y_q    <= '0;
                    mode_q <= 1'b0;
                end else if (en) begin
                    x_q    <= x_src[WIDTH-1:HI];
                    y_q    <= y_src[WIDTH-1:HI];
                    mode_q <= mode_src;
                end
            end
        end

`ifdef CLA_FLAGS_EN
        if (k == NB - 1) begin : g_flags
            logic ovf_q;
            logic zero_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en) begin
                    ovf_q  <= (x_src[WIDTH-1] == yb[BLOCK-1]) && (s[BLOCK-1] != x_src[WIDTH-1]);
                    zero_q <= (res_d == '0);
                end
            end
        end
`endif
    end

    assign out_valid = g_st[NB-1].vld_q;
    assign sum       = g_st[NB-1].res_q;
    assign cout      = g_st[NB-1].c_q;

`ifdef CLA_FLAGS_EN
    assign ovf  = g_st[NB-1].g_flags.ovf_q;
    assign zero = g_st[NB-1].g_flags.zero_q;
`endif

endmodule

// One BLOCK-bit slice: every carry is a flat sum of generate/propagate products.
module cla_slice #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             c_i,
    output logic [BLOCK-1:0] s_o,
    output logic             c_o
);
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;
    logic             acc;
    logic             pr;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pr   = 1'b0;
        c[0] = c_i;
        for (int i = 0; i < BLOCK; i++) begin
            acc = g[i];
            pr  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pr & g[j]);
                pr  = pr & p[j];
            end
            c[i+1] = acc | (pr & c_i);
        end
    end

    assign s_o = p ^ c[BLOCK-1:0];
    assign c_o = c[BLOCK];

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;
    localparam int W  = 16;
    localparam int B  = 4;
    localparam int NB = W / B;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         mode;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
`ifdef CLA_FLAGS_EN
    logic         ovf;
    logic         zero;
`endif

    int checks = 0;
    int errors = 0;
    logic [W+2:0] q[$];

    pipelined_cla_addsub #(.WIDTH(W), .BLOCK(B)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .mode      (mode),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CLA_FLAGS_EN
        ,
        .ovf       (ovf),
        .zero      (zero)
`endif
    );

    always #5 clk = ~clk;

    // {zero, ovf, cout, sum} straight from the arithmetic definition.
    function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic m, input logic c);
        logic [W-1:0] yb;
        logic [W:0]   t;
        logic         v;
        logic         z;
        yb = b ^ {W{m}};
        t  = {1'b0, a} + {1'b0, yb} + {{W{1'b0}}, c};
        v  = (a[W-1] == yb[W-1]) && (t[W-1] != a[W-1]);
        z  = (t[W-1:0] == '0);
        return {z, v, t};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
            if (q.size() == 0) begin
                check("out_valid_unexpected", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                check("out_sum", 32'(sum), 32'(q[0][W-1:0]));
                check("out_cout", 32'(cout), 32'(q[0][W]));
`ifdef CLA_FLAGS_EN
                check("out_ovf", 32'(ovf), 32'(q[0][W+1]));
                check("out_zero", 32'(zero), 32'(q[0][W+2]));
`endif
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(x, y, mode, cin));
        end
    end

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic m, input logic c, input logic [W+2:0] exp);
        int n;
        drain();
        check({name, "_model"}, 32'(model(a, b, m, c)), 32'(exp));
        @(posedge clk); #1;
        x = a; y = b; mode = m; cin = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check({name, "_latency"}, 32'(n), 32'(NB));
        check({name, "_sum"}, 32'(sum), 32'(exp[W-1:0]));
        check({name, "_cout"}, 32'(cout), 32'(exp[W]));
`ifdef CLA_FLAGS_EN
        check({name, "_ovf"}, 32'(ovf), 32'(exp[W+1]));
        check({name, "_zero"}, 32'(zero), 32'(exp[W+2]));
`endif
    endtask

    task automatic rand_op();
        case ($urandom_range(0, 7))
            0:       x = 16'hFFFF;
            1:       x = 16'h8000;
            2:       x = 16'h7FFF;
            default: x = 16'($urandom);
        endcase
        y    = ($urandom_range(0, 5) == 0) ? 16'h0001 : 16'($urandom);
        mode = 1'($urandom);
        cin  = 1'($urandom);
    endtask

    initial begin
        int first_acc;
        int last_acc;
        int n_acc;
        logic saw_low;
        logic need_new;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; mode = 1'b0; cin = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef CLA_FLAGS_EN
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
`endif
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        do_op("t1_add",    16'h1234, 16'h0FED, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h2221});
        do_op("t2_carry",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 16'h0000});
        do_op("t3_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 1'b0, 16'hFFFE});
        do_op("t3_sub",    16'h0007, 16'h0005, 1'b1, 1'b1, {1'b0, 1'b0, 1'b1, 16'h0002});
        do_op("t6_povf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 16'h8000});
        do_op("t6_novf",   16'h8000, 16'h0001, 1'b1, 1'b1, {1'b0, 1'b1, 1'b1, 16'h7FFF});

        // Eight back-to-back ops with a three-cycle output stall mid-stream.
        drain();
        @(posedge clk); #1;
        first_acc = -1; last_acc = -1; n_acc = 0; saw_low = 1'b0; need_new = 1'b1;
        for (int c = 0; c < 40 && n_acc < 8; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            in_valid  = 1'b1;
            if (need_new) rand_op();
            @(negedge clk);
            if (in_ready) begin
                if (first_acc < 0) first_acc = c;
                last_acc = c;
                n_acc++;
                need_new = 1'b1;
            end else begin
                need_new = 1'b0;
                if (out_valid && !out_ready) saw_low = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stream_accepted", 32'(n_acc), 32'd8);
        check("stream_ready_drop", 32'(saw_low), 32'd1);
        check("stream_span", 32'(last_acc - first_acc), 32'd10);
        drain();

        // Asynchronous reset with a held result plus three ops in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            if (i == 0) begin
                x = 16'h1111; y = 16'h2222; mode = 1'b0; cin = 1'b0;
            end else begin
                rand_op();
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_sum", 32'(sum), 32'h3333);
        #2;
        reset = 1'b1;
        q.delete();
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_sum", 32'(sum), 32'd0);
        check("async_rst_cout", 32'(cout), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); @(posedge clk); #3;
        reset = 1'b0;
        @(negedge clk);
        check("rel2_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_stale_valid", 32'(out_valid), 32'd0);
        end
        do_op("post_rst", 16'h1234, 16'h0FED, 1'b0, 1'b0, {1'b0, 1'b0, 1'b0, 16'h2221});

        // Random traffic with random back-pressure, checked by the monitor.
        drain();
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_op();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
